// File: rtl/button_conditioner.sv
// Four-bit pushbutton conditioner: 2-flop synchroniser, per-bit debounce FSM and press pulses.
// Define BTN_LATCH_EN to present sticky press flags on btn_out, cleared by rd_ack.
module button_conditioner #(
    parameter logic [23:0] DEBOUNCE_COUNT = 24'd10_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       rd_ack,
    output logic [3:0] btn_level,
    output logic [3:0] press_pulse,
    output logic [3:0] btn_out
);

    localparam logic [23:0] LastCount = DEBOUNCE_COUNT - 24'd1;

    typedef enum logic {
        StStable,
        StConfirm
    } state_t;

    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_bit
        state_t      state;
        logic [23:0] counter;
        logic        level;
        logic        pulse;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state   <= StStable;
                counter <= '0;
                level   <= 1'b0;
                pulse   <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    StStable: begin
                        if (sync2[i] != level) begin
                            state   <= StConfirm;
                            counter <= 24'd1;
                        end else begin
                            counter <= '0;
                        end
                    end
                    StConfirm: begin
                        if (sync2[i] == level) begin
                            // Glitch: input fell back before the count completed.
                            state   <= StStable;
                            counter <= '0;
                        end else if (counter == LastCount) begin
                            level   <= sync2[i];
                            pulse   <= sync2[i];
                            counter <= '0;
                            state   <= StStable;
                        end else begin
                            counter <= counter + 24'd1;
                        end
                    end
                    default: begin
                        state   <= StStable;
                        counter <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level;
        assign press_pulse[i] = pulse;
    end

`ifdef BTN_LATCH_EN
    logic [3:0] sticky;

    // A coincident press wins over the read acknowledge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~{4{rd_ack}}) | press_pulse;
        end
    end

    assign btn_out = sticky;
`else
    logic unused_rd_ack;
    assign unused_rd_ack = rd_ack;
    assign btn_out       = btn_level;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_COUNT = 4; expected outputs are
// queued per cycle by the stimulus and checked by an independent monitor.
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       rd_ack;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] btn_out;

`ifdef BTN_LATCH_EN
    localparam bit Latch = 1'b1;
`else
    localparam bit Latch = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] pulse;
        logic [3:0] out;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         vec_no = 0;
    logic [3:0] exp_sticky = '0;
    logic [3:0] prev_pulse = '0;

    button_conditioner #(
        .DEBOUNCE_COUNT(24'd4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .rd_ack     (rd_ack),
        .btn_level  (btn_level),
        .press_pulse(press_pulse),
        .btn_out    (btn_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    // One vector per cycle: inputs are sampled at the next rising edge, expectation is for
    // the outputs just after that edge.
    task automatic cyc(input logic [3:0] raw, input logic ack, input int n,
                       input logic [3:0] lvl, input logic [3:0] pls);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            reset   = 1'b0;
            btn_raw = raw;
            rd_ack  = ack;
            e.level = lvl;
            e.pulse = pls;
            if (Latch) begin
                exp_sticky = (exp_sticky & ~{4{ack}}) | prev_pulse;
                e.out      = exp_sticky;
            end else begin
                e.out = lvl;
            end
            prev_pulse = pls;
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_now_level", vec_no, btn_level, 4'b0000);
        chk("rst_now_pulse", vec_no, press_pulse, 4'b0000);
        chk("rst_now_out", vec_no, btn_out, 4'b0000);
        exp_sticky = '0;
        prev_pulse = '0;
        e = '0;
        q.push_back(e);
    endtask

    // Monitor: compares whatever expectation is queued for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                vec_no++;
                chk("level", vec_no, btn_level, e.level);
                chk("pulse", vec_no, press_pulse, e.pulse);
                chk("out", vec_no, btn_out, e.out);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout pending=%0d required=0", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        rd_ack  = 1'b0;
        @(negedge clock);
        chk("reset_level", 0, btn_level, 4'b0000);
        chk("reset_pulse", 0, press_pulse, 4'b0000);
        chk("reset_out", 0, btn_out, 4'b0000);

        // Bit 0 press: level and pulse after the 6th edge; rd_ack coincident with the pulse.
        cyc(4'b0001, 1'b0, 5, 4'b0000, 4'b0000);
        cyc(4'b0001, 1'b0, 1, 4'b0001, 4'b0001);
        cyc(4'b0001, 1'b1, 1, 4'b0001, 4'b0000);
        cyc(4'b0001, 1'b0, 2, 4'b0001, 4'b0000);
        cyc(4'b0001, 1'b1, 1, 4'b0001, 4'b0000);
        cyc(4'b0001, 1'b0, 1, 4'b0001, 4'b0000);
        cyc(4'b0000, 1'b1, 5, 4'b0001, 4'b0000);
        cyc(4'b0000, 1'b0, 1, 4'b0000, 4'b0000);
        cyc(4'b0000, 1'b0, 2, 4'b0000, 4'b0000);

        // Three-cycle glitch on bit 1 is rejected.
        cyc(4'b0010, 1'b0, 3, 4'b0000, 4'b0000);
        cyc(4'b0000, 1'b0, 6, 4'b0000, 4'b0000);

        // Two bits together, then release with no pulse.
        cyc(4'b1010, 1'b0, 5, 4'b0000, 4'b0000);
        cyc(4'b1010, 1'b0, 1, 4'b1010, 4'b1010);
        cyc(4'b1010, 1'b0, 2, 4'b1010, 4'b0000);
        cyc(4'b0000, 1'b0, 5, 4'b1010, 4'b0000);
        cyc(4'b0000, 1'b0, 1, 4'b0000, 4'b0000);
        cyc(4'b0000, 1'b0, 2, 4'b0000, 4'b0000);

        // Bit 3 press, five cycles, then a read acknowledge.
        cyc(4'b1000, 1'b0, 5, 4'b0000, 4'b0000);
        cyc(4'b1000, 1'b0, 1, 4'b1000, 4'b1000);
        cyc(4'b1000, 1'b0, 5, 4'b1000, 4'b0000);
        cyc(4'b1000, 1'b1, 1, 4'b1000, 4'b0000);
        cyc(4'b1000, 1'b0, 2, 4'b1000, 4'b0000);
        cyc(4'b0000, 1'b0, 5, 4'b1000, 4'b0000);
        cyc(4'b0000, 1'b0, 1, 4'b0000, 4'b0000);
        cyc(4'b0000, 1'b0, 1, 4'b0000, 4'b0000);

        // Reset two cycles into bit 2's confirm window, with bit 0 already pressed.
        cyc(4'b0001, 1'b0, 5, 4'b0000, 4'b0000);
        cyc(4'b0001, 1'b0, 1, 4'b0001, 4'b0001);
        cyc(4'b0001, 1'b0, 2, 4'b0001, 4'b0000);
        cyc(4'b0101, 1'b0, 4, 4'b0001, 4'b0000);
        do_reset();
        cyc(4'b0101, 1'b0, 5, 4'b0000, 4'b0000);
        cyc(4'b0101, 1'b0, 1, 4'b0101, 4'b0101);
        cyc(4'b0101, 1'b0, 2, 4'b0101, 4'b0000);
        cyc(4'b0000, 1'b0, 5, 4'b0101, 4'b0000);
        cyc(4'b0000, 1'b0, 1, 4'b0000, 4'b0000);
        cyc(4'b0000, 1'b0, 1, 4'b0000, 4'b0000);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL provide parameter DEBOUNCE_COUNT, default 24'd10_000; the number of consecutive cycles a synchronised input must differ from its debounced level before that level changes; legal range 2..2^24-1.
REQ-002 SHALL provide port clock, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL provide port btn_raw, input, 4, unsynchronised pushbutton levels; 1 = pressed.
REQ-005 SHALL provide port rd_ack, input, 1, single-cycle strobe, high on the cycle the processor reads the buttons (input-buffer enable).
REQ-006 SHALL provide port btn_level, output, 4, debounced level per button.
REQ-007 SHALL provide port press_pulse, output, 4, one-cycle pulse per debounced 0->1 transition.
REQ-008 SHALL provide port btn_out, output, 4, value presented to the processor data-bus input buffer.

Function
REQ-009 SHALL pass each btn_raw bit through a 2-flop synchroniser; s[i] denotes the second-flop output.
REQ-010 SHALL run one independent 2-state FSM per bit: STABLE and CONFIRM.
REQ-011 In STABLE, when s[i] != btn_level[i], SHALL enter CONFIRM with counter[i] = 1; otherwise SHALL hold with counter[i] = 0.
REQ-012 In CONFIRM, when s[i] == btn_level[i], SHALL return to STABLE with counter[i] = 0 (glitch rejected; btn_level unchanged).
REQ-013 In CONFIRM, when s[i] != btn_level[i] and counter[i] == DEBOUNCE_COUNT-1, SHALL set btn_level[i] = s[i], clear counter[i] and return to STABLE; otherwise SHALL increment counter[i].
REQ-014 Latency SHALL be exactly 2 + DEBOUNCE_COUNT clock edges from the first edge that samples a new, held btn_raw value to btn_level updating.
REQ-015 counter[i] SHALL be 24 bits; it SHALL never exceed DEBOUNCE_COUNT-1 and SHALL never wrap.
REQ-016 press_pulse[i] SHALL be high for exactly the one cycle following the edge at which btn_level[i] goes 0->1; release SHALL generate no pulse.
REQ-017 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL each complete with the REQ-014 latency.
REQ-018 Outputs SHALL be registered, with no combinational path from btn_raw or rd_ack to any output.

Reset
REQ-019 Asserting reset SHALL immediately clear synchronisers, counters, btn_level, press_pulse, btn_out and any sticky flags, and SHALL place all FSMs in STABLE.
REQ-020 Reset asserted mid-CONFIRM SHALL abandon the pending transition; after release, a held-pressed button SHALL take the full REQ-014 latency to appear.

Configuration
REQ-021 With macro BTN_LATCH_EN defined, SHALL keep sticky[3:0], set by press_pulse and cleared by rd_ack, and SHALL drive btn_out = sticky.
REQ-022 With BTN_LATCH_EN defined, SHALL give set priority when press_pulse[i] and rd_ack occur in the same cycle (sticky[i] stays 1); rd_ack SHALL clear only bits without a coincident press.
REQ-023 With BTN_LATCH_EN undefined, SHALL drive btn_out = btn_level, SHALL ignore rd_ack and SHALL contain no sticky registers.

Verification (DEBOUNCE_COUNT = 4)
REQ-024 Hold btn_raw = 4'b0001 from edge 0 -> btn_level = 4'b0001 after edge 6, with press_pulse[0] high for the one cycle following edge 6.
REQ-025 btn_raw[1] high for 3 cycles, then low -> btn_level[1] and press_pulse[1] stay 0 throughout.
REQ-026 btn_raw = 4'b1010 held, then released after btn_level updates -> btn_level returns to 4'b0000 6 edges after release; no release pulse.
REQ-027 Reset asserted 2 cycles into CONFIRM with btn_raw[2] held -> all outputs 0 immediately; after release, btn_level[2] rises 6 edges later.
REQ-028 BTN_LATCH_EN defined: press bit 3, wait 5 cycles, then pulse rd_ack -> btn_out = 4'b1000 until the edge after rd_ack, then 4'b0000; rd_ack coincident with press_pulse[0] -> btn_out[0] remains 1.
REQ-029 BTN_LATCH_EN undefined: btn_out tracks btn_level on every cycle, and rd_ack toggling has no effect.
